// File: rtl/picomem_gpio_irq.sv
// GPIO peripheral for the PicoRV32 native memory bus: WIDTH tristate pins,
// synchronised input path, atomic set/clear/toggle of OUT, and per-pin
// rising/falling edge detection with sticky pending bits driving a level irq.
module picomem_gpio_irq #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000,
    parameter logic [31:0] OE_RESET    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             busin_valid,
    input  logic [31:0]      busin_addr,
    input  logic [31:0]      busin_wdata,
    input  logic [3:0]       busin_wstrb,
    output logic             busin_ready,
    output logic [31:0]      busin_rdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] io
);

    localparam int unsigned CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(SYNC_STAGES);

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Expands byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  out_q, out_d, oe_q, oe_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              ready_q, irq_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              accept_s, write_s;
    logic [31:0]       bmask_s, wbits_s, rd_s;
    logic [WIDTH-1:0]  bm_s, dv_s, w1c_s, sync_s, event_s;
    logic              unused_s;

    assign accept_s = busin_valid & ~ready_q;
    assign write_s  = accept_s & (busin_wstrb != 4'b0000);
    assign bmask_s  = strb_to_mask(busin_wstrb);
    assign wbits_s  = busin_wdata & bmask_s;
    assign bm_s     = bmask_s[WIDTH-1:0];
    assign dv_s     = wbits_s[WIDTH-1:0];
    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign unused_s = ^{busin_addr[31:6], busin_addr[1:0], bmask_s, wbits_s};

    // Pads are driven only where the output enable is set.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_pad
        assign io[g] = oe_q[g] ? out_q[g] : 1'bz;
    end

    // Edges are only reported once the synchroniser and prev stage hold real pin data.
    always_comb begin
        if (state_q == RUN) begin
            event_s = (sync_s & ~prev_q & rise_en_q) | (~sync_s & prev_q & fall_en_q);
        end else begin
            event_s = {WIDTH{1'b0}};
        end
    end

    // Warm-up sequencing: count SYNC_STAGES cycles, then arm edge detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARM: begin
                if (cnt_q == CNT_DONE) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = WARM;
        endcase
    end

    // Read mux: value of the addressed register before any write this cycle.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (busin_addr[5:2])
            4'd0:    rd_s[WIDTH-1:0] = out_q;
            4'd1:    rd_s[WIDTH-1:0] = sync_s;
            4'd2:    rd_s[WIDTH-1:0] = oe_q;
            4'd3,
            4'd4,
            4'd5:    rd_s = 32'h0000_0000;
            4'd6:    rd_s[WIDTH-1:0] = rise_en_q;
            4'd7:    rd_s[WIDTH-1:0] = fall_en_q;
            4'd8:    rd_s[WIDTH-1:0] = pend_q;
            default: rd_s = 32'hDEAD_BEEF;
        endcase
    end

    // Register write decode; a new edge event wins over a same-cycle W1C.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_s     = {WIDTH{1'b0}};
        if (write_s) begin
            case (busin_addr[5:2])
                4'd0:    out_d     = (out_q & ~bm_s) | dv_s;
                4'd2:    oe_d      = (oe_q & ~bm_s) | dv_s;
                4'd3:    out_d     = out_q | dv_s;
                4'd4:    out_d     = out_q & ~dv_s;
                4'd5:    out_d     = out_q ^ dv_s;
                4'd6:    rise_en_d = (rise_en_q & ~bm_s) | dv_s;
                4'd7:    fall_en_d = (fall_en_q & ~bm_s) | dv_s;
                4'd8:    w1c_s     = dv_s;
                default: w1c_s     = {WIDTH{1'b0}};
            endcase
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        pend_d  = (pend_q & ~w1c_s) | event_s;
        rdata_d = accept_s ? rd_s : rdata_q;
    end

    // Input synchroniser chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
            prev_q <= {WIDTH{1'b0}};
        end else begin
            sync_q[0] <= io;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_s;
        end
    end

    // Architectural registers, bus handshake and warm-up state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WARM;
            cnt_q     <= {CW{1'b0}};
            out_q     <= OUT_RESET[WIDTH-1:0];
            oe_q      <= OE_RESET[WIDTH-1:0];
            rise_en_q <= {WIDTH{1'b0}};
            fall_en_q <= {WIDTH{1'b0}};
            pend_q    <= {WIDTH{1'b0}};
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            ready_q   <= accept_s;
            rdata_q   <= rdata_d;
            irq_q     <= |pend_d;
        end
    end

    assign busin_ready = ready_q;
    assign busin_rdata = rdata_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_picomem_gpio_irq.sv
// Scoreboard bench for picomem_gpio_irq: a 32-pin and an 8-pin instance see the
// same bus traffic; a cycle-level reference model predicts every response.
module tb_picomem_gpio_irq;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        ready32, ready8, irq32, irq8;
    logic [31:0] rdata32, rdata8;
    wire  [31:0] io;
    wire  [7:0]  io8;
    logic [31:0] drv = 32'hFFFF_FFFF;
    logic [31:0] tb_oe0 = 32'hFF, tb_oe1 = 32'hFF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    picomem_gpio_irq #(.WIDTH(32), .SYNC_STAGES(S), .OUT_RESET(32'hA5), .OE_RESET(32'hFF)) u_dut32 (
        .clk(clk), .resetn(resetn), .busin_valid(valid), .busin_addr(addr),
        .busin_wdata(wdata), .busin_wstrb(wstrb), .busin_ready(ready32),
        .busin_rdata(rdata32), .irq(irq32), .io(io));

    picomem_gpio_irq #(.WIDTH(8), .SYNC_STAGES(S), .OUT_RESET(32'hA5), .OE_RESET(32'hFF)) u_dut8 (
        .clk(clk), .resetn(resetn), .busin_valid(valid), .busin_addr(addr),
        .busin_wdata(wdata), .busin_wstrb(wstrb), .busin_ready(ready8),
        .busin_rdata(rdata8), .irq(irq8), .io(io8));

    for (genvar g = 0; g < 32; g++) begin : g_drv32
        assign io[g] = tb_oe0[g] ? 1'bz : drv[g];
    end
    for (genvar g = 0; g < 8; g++) begin : g_drv8
        assign io8[g] = tb_oe1[g] ? 1'bz : drv[g];
    end

    // ---------------- reference model ----------------
    logic [31:0] m_out[2], m_oe[2], m_re[2], m_fe[2], m_pend[2], m_in[2], m_inprev[2], m_rdata[2];
    logic [31:0] samp0[$], samp1[$];
    logic        m_ready;
    int          m_edges;

    typedef struct packed { logic [31:0] e0; logic [31:0] e1; } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] wm(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [3:0] a);
        case (a)
            4'd0: return m_out[d];
            4'd1: return m_in[d];
            4'd2: return m_oe[d];
            4'd3, 4'd4, 4'd5: return 32'h0;
            4'd6: return m_re[d];
            4'd7: return m_fe[d];
            4'd8: return m_pend[d];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 32'hA5 & wm(d);
            m_oe[d] = 32'hFF & wm(d);
            m_re[d] = 32'h0; m_fe[d] = 32'h0; m_pend[d] = 32'h0;
            m_in[d] = 32'h0; m_inprev[d] = 32'h0; m_rdata[d] = 32'h0;
        end
        samp0.delete(); samp1.delete(); exp_q.delete();
        m_ready = 1'b0; m_edges = 0;
    endtask

    task automatic m_step();
        logic acc;
        logic [31:0] pin, ev, bm, dv, w1c;
        exp_t e;
        acc = valid && !m_ready;
        m_edges++;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            pin = ((m_oe[d] & m_out[d]) | (~m_oe[d] & drv)) & wm(d);
            ev = 32'h0;
            if (m_edges >= S + 2)
                ev = (m_in[d] & ~m_inprev[d] & m_re[d]) | (~m_in[d] & m_inprev[d] & m_fe[d]);
            w1c = 32'h0;
            if (acc) begin
                m_rdata[d] = model_read(d, addr[5:2]);
                if (d == 0) e.e0 = m_rdata[d]; else e.e1 = m_rdata[d];
                if (wstrb != 4'h0) begin
                    bm = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}} & wm(d);
                    dv = wdata & bm;
                    case (addr[5:2])
                        4'd0: m_out[d] = (m_out[d] & ~bm) | dv;
                        4'd2: m_oe[d]  = (m_oe[d] & ~bm) | dv;
                        4'd3: m_out[d] = m_out[d] | dv;
                        4'd4: m_out[d] = m_out[d] & ~dv;
                        4'd5: m_out[d] = m_out[d] ^ dv;
                        4'd6: m_re[d]  = (m_re[d] & ~bm) | dv;
                        4'd7: m_fe[d]  = (m_fe[d] & ~bm) | dv;
                        4'd8: w1c = dv;
                        default: ;
                    endcase
                end
            end
            m_pend[d] = (m_pend[d] & ~w1c) | ev;
            m_inprev[d] = m_in[d];
            if (d == 0) begin
                samp0.push_back(pin);
                if (samp0.size() >= S) m_in[d] = samp0.pop_front();
            end else begin
                samp1.push_back(pin);
                if (samp1.size() >= S) m_in[d] = samp1.pop_front();
            end
        end
        if (acc) exp_q.push_back(e);
        m_ready = acc;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) m_reset();
            else m_step();
        end
    end

    // Bench pin drivers back off wherever the model says the DUT drives.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            tb_oe0 = m_oe[0];
            tb_oe1 = m_oe[1];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                chk("ready32", {31'h0, ready32}, {31'h0, m_ready});
                chk("ready8", {31'h0, ready8}, {31'h0, m_ready});
                chk("irq32", {31'h0, irq32}, {31'h0, |m_pend[0]});
                chk("irq8", {31'h0, irq8}, {31'h0, |m_pend[1]});
                chk("io32", io & m_oe[0], m_out[0] & m_oe[0]);
                chk("io8", {24'h0, io8} & m_oe[1], m_out[1] & m_oe[1]);
                if (ready32) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ready got 1 expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata32", rdata32, e.e0);
                        chk("rdata8", rdata8, e.e1);
                    end
                end else begin
                    chk("hold32", rdata32, m_rdata[0]);
                    chk("hold8", rdata8, m_rdata[1]);
                end
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] r0, output logic [31:0] r1);
        bit got;
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = wd; wstrb = ws;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ready32) got = 1'b1;
        end
        r0 = rdata32; r1 = rdata8;
        valid = 1'b0; wstrb = 4'h0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL bus_timeout got no ready expected ready within 8 cycles");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_io", {24'h0, io[7:0]}, 32'hA5);
        chk("rst_irq", {31'h0, irq32}, 32'h0);
        bus(32'h20, 32'h0, 4'h0, r0, r1);
        chk("rst_pend", r0, 32'h0);

        // atomic set/clear/toggle
        bus(32'h00, 32'h0, 4'hF, r0, r1);
        bus(32'h08, 32'hFFFF_FFFF, 4'hF, r0, r1);
        bus(32'h0C, 32'h0000_00F0, 4'hF, r0, r1);
        bus(32'h10, 32'h0000_0030, 4'hF, r0, r1);
        bus(32'h14, 32'h0000_0101, 4'hF, r0, r1);
        bus(32'h00, 32'h0, 4'h0, r0, r1);
        chk("out_atomic", r0, 32'h0000_01C1);
        chk("out_atomic8", r1, 32'h0000_00C1);
        bus(32'h0C, 32'h0, 4'h0, r0, r1);
        chk("set_reads0", r0, 32'h0);

        // byte strobes
        bus(32'h00, 32'h0, 4'hF, r0, r1);
        bus(32'h00, 32'h1122_3344, 4'b0100, r0, r1);
        bus(32'h00, 32'h0, 4'h0, r0, r1);
        chk("byte_strobe", r0, 32'h0022_0000);
        chk("byte_strobe8", r1, 32'h0);

        // rising edge on pin 3
        bus(32'h08, 32'h0, 4'hF, r0, r1);
        @(negedge clk); drv = 32'h0;
        repeat (6) @(negedge clk);
        bus(32'h18, 32'h8, 4'hF, r0, r1);
        bus(32'h1C, 32'h0, 4'hF, r0, r1);
        bus(32'h20, 32'hFFFF_FFFF, 4'hF, r0, r1);
        @(negedge clk); drv[3] = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_before", {31'h0, irq32}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'h0, irq32}, 32'h1);
        bus(32'h04, 32'h0, 4'h0, r0, r1);
        chk("in_bit3", r0 & 32'h8, 32'h8);
        bus(32'h20, 32'h0, 4'h0, r0, r1);
        chk("pend_rise", r0, 32'h8);
        bus(32'h20, 32'h8, 4'hF, r0, r1);
        chk("irq_w1c", {31'h0, irq32}, 32'h0);
        @(negedge clk); drv[3] = 1'b0;
        repeat (5) @(negedge clk);
        bus(32'h20, 32'h0, 4'h0, r0, r1);
        chk("fall_disabled", r0, 32'h0);

        // event on bit 0 in the same cycle as its W1C
        bus(32'h18, 32'h1, 4'hF, r0, r1);
        @(negedge clk); drv[0] = 1'b1;
        @(negedge clk);
        bus(32'h20, 32'h1, 4'h1, r0, r1);
        bus(32'h20, 32'h0, 4'h0, r0, r1);
        chk("event_wins", r0 & 32'h1, 32'h1);
        bus(32'h20, 32'hFFFF_FFFF, 4'hF, r0, r1);

        // unmapped address and narrow-width masking
        bus(32'h28, 32'h0, 4'h0, r0, r1);
        chk("unmapped", r0, 32'hDEAD_BEEF);
        chk("unmapped8", r1, 32'hDEAD_BEEF);
        bus(32'h00, 32'hFFFF_FFFF, 4'hF, r0, r1);
        bus(32'h00, 32'h0, 4'h0, r0, r1);
        chk("out_full", r0, 32'hFFFF_FFFF);
        chk("out_w8", r1, 32'h0000_00FF);

        // reset during a transfer aborts it
        bus(32'h00, 32'h12, 4'hF, r0, r1);
        @(negedge clk);
        valid = 1'b1; addr = 32'h0; wdata = 32'h55; wstrb = 4'hF;
        #2 resetn = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'h0, ready32}, 32'h0);
        valid = 1'b0; wstrb = 4'h0; resetn = 1'b1;
        bus(32'h00, 32'h0, 4'h0, r0, r1);
        chk("abort_out", r0, 32'hA5);

        // randomized traffic and pin activity
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) drv = drv ^ $urandom();
            bus({$urandom() & 32'hFFFF_FFC3} | {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom(),
                ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom()),
                r0, r1);
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picomem_gpio_irq.md
# picomem_gpio_irq

Parametrised GPIO peripheral for the PicoRV32 native memory bus, with WIDTH bidirectional pins. It adds the following over a plain out/in/oe port:
- a synchronised input path;
- atomic set/clear/toggle of the output register;
- per-pin rising/falling edge detection with sticky pending bits and a level interrupt output.

It sits on the peripheral bus decoder alongside the other PicoMem slaves and drives top-level pads directly.

## Interface
Parameters:
- WIDTH, 32: number of pins, 1..32; register bits [31:WIDTH] read 0, writes to them ignored.
- SYNC_STAGES, 2: input synchroniser depth, ≥2.
- OUT_RESET, 0: reset value of OUT[WIDTH-1:0].
- OE_RESET, 0: reset value of OE[WIDTH-1:0].

Ports:
- clk  in  1  single clock, all logic rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- busin_valid  in  1  bus request.
- busin_addr  in  32  byte address; only [5:2] decoded.
- busin_wdata  in  32  write data.
- busin_wstrb  in  4  byte write strobes; all zero = read.
- busin_ready  out  1  one-cycle acknowledge.
- busin_rdata  out  32  read data, valid while busin_ready is high.
- irq  out  1  level interrupt, equals OR of PEND.
- io  inout  WIDTH  pads; io[i] = OE[i] ? OUT[i] : Z.

## Operation
Register map (addr[5:2]):
- 0 OUT: RW.
- 1 IN: RO, synchronised pin value.
- 2 OE: RW.
- 3 OUT_SET: W1S into OUT, reads 0.
- 4 OUT_CLR: W1C into OUT, reads 0.
- 5 OUT_TGL: write-1 toggles OUT, reads 0.
- 6 RISE_EN: RW.
- 7 FALL_EN: RW.
- 8 PEND: RW1C.
- 9..15: reads 32'hDEADBEEF, writes ignored.

Write and read behaviour:
- Byte strobes apply to every writable register, including set/clear/toggle/PEND; unstrobed bytes are untouched.
- A transfer is accepted when busin_valid && !busin_ready.
- busin_rdata captures the pre-write register value at acceptance and holds until the next accepted transfer.

Input path and edge detection:
- Pad → SYNC_STAGES flops → sync; prev <= sync each cycle.
- rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
- PEND <= (PEND & ~w1c_mask) | rise | fall. A new event wins over a same-cycle clear of the same bit.
- Clearing RISE_EN/FALL_EN does not clear PEND.

Warm-up state machine, states WARM → RUN:
- Reset enters WARM, counter = 0.
- The counter increments each cycle in WARM; the block moves to RUN when the counter reaches SYNC_STAGES.
- Edge events are suppressed in WARM, so pins held high through reset never raise PEND.
- Bus accesses are serviced in both states.

## Timing
Reset values (asynchronous):
- busin_ready = 0, busin_rdata = 0, irq = 0.
- OUT = OUT_RESET, OE = OE_RESET.
- RISE_EN = FALL_EN = PEND = 0.
- Sync chain and prev = 0; state WARM.

Bus timing:
- busin_ready rises one cycle after accepted busin_valid and is high exactly one cycle.
- Back-to-back requests therefore take 2 cycles each.
- Register updates from a write take effect at the same edge that raises busin_ready; io reflects OUT/OE changes from that edge.

Input latency:
- A pad change stable before edge k appears in IN after edge k+SYNC_STAGES-1.
- The corresponding PEND bit sets at edge k+SYNC_STAGES.
- irq is high from that edge, and drops the edge after a W1C clears the last pending bit.

Boundary and mid-operation behaviour:
- Assertion of resetn during a transfer aborts it: ready stays 0 and no register is written.
- Pulses shorter than one clock may be missed; no guarantee below one period.

## Test plan
- Reset with OUT_RESET=32'hA5, OE_RESET=32'hFF, all pins pulled high → io[7:0]=8'hA5, io[31:8]=Z; after 10 cycles PEND=0, irq=0.
- Write OUT=0, OE=32'hFFFF_FFFF; OUT_SET 32'h0000_00F0; OUT_CLR 32'h0000_0030; OUT_TGL 32'h0000_0101 → OUT reads 32'h0000_01C1; OUT_SET read returns 0.
- Byte strobe: OUT=0, write 32'h1122_3344 with wstrb=4'b0100 → OUT=32'h0022_0000; each ready pulse is exactly 1 cycle, asserted 1 cycle after valid.
- RISE_EN bit 3 set, drive io[3] 0→1 → IN[3]=1 after 2 edges, PEND=32'h8 and irq=1 after 3; W1C 32'h8 → irq=0 next cycle. The falling edge with FALL_EN=0 leaves PEND=0.
- Same-cycle rising edge on bit 0 and a W1C of bit 0 → PEND[0] remains 1.
- WIDTH=8 build: write 32'hFFFF_FFFF to OUT → reads 32'h0000_00FF. Address 0x28 reads 32'hDEADBEEF. resetn pulsed low mid-write → register unchanged, ready=0.
